// File: rtl/data_bus.sv
// data_bus: core data-port fabric with word RAM, TX byte FIFO and a
// free-running cycle counter, all behind one byte-addressed port.
module data_bus #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0] TXDATA_W = 30'h2000_0000;
    localparam logic [29:0] TXSTAT_W = 30'h2000_0001;
    localparam logic [29:0] CYCLE_W  = 30'h2000_0002;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic [29:0]    waddr;
    logic [AW-1:0]  ram_idx;
    logic           ram_hit;
    logic           hit_tx;
    logic           hit_stat;
    logic           hit_cyc;
    logic           unmapped;

    assign waddr    = d_addr[31:2];
    assign ram_idx  = d_addr[AW+1:2];
    assign ram_hit  = (d_addr[31:AW+2] == '0);
    assign hit_tx   = (waddr == TXDATA_W);
    assign hit_stat = (waddr == TXSTAT_W);
    assign hit_cyc  = (waddr == CYCLE_W);
    assign unmapped = !(ram_hit || hit_tx
                        || hit_stat || hit_cyc);

    // ---------------- write qualification ----------------
    logic we_byte;
    logic we_half;
    logic we_word;
    logic we_any;
    logic misal;
    logic wr_ok;

    assign we_byte = (d_we == 2'b01);
    assign we_half = (d_we == 2'b10);
    assign we_word = (d_we == 2'b11);
    assign we_any  = (d_we != 2'b00);
    assign misal   = (we_half && d_addr[0])
                   || (we_word && (d_addr[1:0] != 2'b00));
    assign wr_ok   = we_any && !misal;

    // ---------------- RAM ----------------
    logic [31:0] mem [RAM_WORDS];
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ram_we;

    assign ram_we = wr_ok && ram_hit;

    // Byte-lane enables and lane-replicated write data.
    always_comb begin
        be    = 4'b0000;
        wdata = d_wr_data;
        unique case (1'b1)
            we_byte: begin
                be[d_addr[1:0]] = 1'b1;
                wdata = {4{d_wr_data[7:0]}};
            end
            we_half: begin
                be = d_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{d_wr_data[15:0]}};
            end
            we_word: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    // RAM array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && be[i]) begin
                mem[ram_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;

    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_ok && hit_tx;
    assign push     = push_req && (!full || pop);
    assign tx_data  = tx_valid ? fifo_mem[rp] : 8'h00;

    // FIFO storage; validity is governed by cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wp] <= d_wr_data[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cyc;
    logic        cyc_load;

    assign cyc_load = wr_ok && hit_cyc && we_word;

    // Free-running counter, loadable by an aligned word write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= '0;
        end else if (cyc_load) begin
            cyc <= d_wr_data;
        end else begin
            cyc <= cyc + 32'd1;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] stat;
    logic [31:0] rd_next;

    assign stat = {{(30-CW){1'b0}}, cnt, empty, full};

    // Select the aligned word seen before this edge's updates.
    always_comb begin
        rd_next = 32'h0;
        unique case (1'b1)
            ram_hit:  rd_next = mem[ram_idx];
            hit_stat: rd_next = stat;
            hit_cyc:  rd_next = cyc;
            default:  rd_next = 32'h0;
        endcase
    end

    // One-cycle registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rd_data <= '0;
        end else begin
            d_rd_data <= rd_next;
        end
    end

    // ---------------- error flag ----------------
    logic err_set;

    assign err_set = we_any && (misal || unmapped
                   || (hit_cyc && !we_word)
                   || (push_req && full && !pop));

    // Sticky error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (err_set) begin
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed stimulus against a byte-array / queue model
// of the data bus, compared every cycle, plus literal spot checks.
module tb_data_bus;

    localparam int RW = 1024;
    localparam int FD = 4;

    localparam logic [31:0] A_TXD  = 32'h8000_0000;
    localparam logic [31:0] A_TXS  = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_IDLE = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  d_we = 2'b00;
    logic [31:0] d_addr = A_IDLE;
    logic [31:0] d_wr_data = 32'h0;
    logic [31:0] d_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    always #5 clk = ~clk;

    data_bus #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wr_data(d_wr_data),
        .d_rd_data(d_rd_data),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_err(bus_err)
    );

    // model state
    logic [7:0]  m_mem [RW*4];
    bit          m_known [RW*4];
    logic [7:0]  q [$];
    logic [31:0] m_cyc = 32'h0;
    bit          m_err = 1'b0;

    // expected outputs after the latest edge
    logic [31:0] e_rd = 32'h0;
    bit          e_rd_ok = 1'b0;
    bit          e_valid = 1'b0;
    logic [7:0]  e_data = 8'h0;
    bit          e_err = 1'b0;
    bit          chk_en = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic void wr_byte(input logic [31:0] a,
                                    input logic [7:0] v);
        m_mem[int'(a)] = v;
        m_known[int'(a)] = 1'b1;
    endfunction

    function automatic void m_read(input logic [31:0] a,
                                   output logic [31:0] v,
                                   output bit ok);
        int w;
        int n;
        v = 32'h0;
        ok = 1'b1;
        n = q.size();
        if (a < RW*4) begin
            w = int'({a[31:2], 2'b00});
            for (int i = 0; i < 4; i++) begin
                v[i*8 +: 8] = m_mem[w+i];
                if (!m_known[w+i]) ok = 1'b0;
            end
        end else if ({a[31:2], 2'b00} == A_TXS) begin
            v = 32'(n) * 4;
            if (n == 0) v = v + 2;
            if (n == FD) v = v + 1;
        end else if ({a[31:2], 2'b00} == A_CYC) begin
            v = m_cyc;
        end
    endfunction

    task automatic tick(input logic [1:0] we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input bit rdy);
        logic [31:0] rv;
        logic [31:0] w;
        bit rok;
        bit pop;
        bit mis;
        bit err;
        bit ld;
        d_we = we;
        d_addr = a;
        d_wr_data = d;
        tx_ready = rdy;
        m_read(a, rv, rok);
        pop = (q.size() != 0) && rdy;
        w = {a[31:2], 2'b00};
        mis = (we == 2'd2 && a[0])
           || (we == 2'd3 && a[1:0] != 2'b00);
        err = 1'b0;
        ld = 1'b0;
        if (pop) void'(q.pop_front());
        if (we != 2'd0) begin
            if (mis) begin
                err = 1'b1;
            end else if (a < RW*4) begin
                if (we == 2'd1) begin
                    wr_byte(a, d[7:0]);
                end else if (we == 2'd2) begin
                    wr_byte(a, d[7:0]);
                    wr_byte(a + 1, d[15:8]);
                end else begin
                    for (int i = 0; i < 4; i++)
                        wr_byte(a + i, d[i*8 +: 8]);
                end
            end else if (w == A_TXD) begin
                if (q.size() >= FD) err = 1'b1;
                else q.push_back(d[7:0]);
            end else if (w == A_TXS) begin
                err = 1'b0;
            end else if (w == A_CYC) begin
                if (we == 2'd3) ld = 1'b1;
                else err = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        if (err) m_err = 1'b1;
        m_cyc = ld ? d : m_cyc + 32'd1;
        @(posedge clk);
        e_rd = rv;
        e_rd_ok = rok;
        e_valid = (q.size() != 0);
        e_data = (q.size() != 0) ? q[0] : 8'h00;
        e_err = m_err;
        #1;
    endtask

    task automatic pop_one(output logic [7:0] b);
        b = tx_data;
        tick(2'd0, A_IDLE, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_rd", d_rd_data, 32'h0);
        chk("rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_txdata", {24'b0, tx_data}, 32'h0);
        chk("rst_err", {31'b0, bus_err}, 32'h0);
        q.delete();
        m_cyc = 32'h0;
        m_err = 1'b0;
        e_rd = 32'h0;
        e_rd_ok = 1'b1;
        e_valid = 1'b0;
        e_data = 8'h0;
        e_err = 1'b0;
        d_we = 2'd0;
        d_addr = A_IDLE;
        tx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (e_rd_ok) chk("rd", d_rd_data, e_rd);
            chk("valid", {31'b0, tx_valid}, {31'b0, e_valid});
            if (e_valid) chk("txdata", {24'b0, tx_data}, {24'b0, e_data});
            chk("err", {31'b0, bus_err}, {31'b0, e_err});
        end
    end

    initial begin
        logic [7:0] b;
        do_reset();

        // RAM byte lanes and read-during-write
        tick(2'd3, 32'h10, 32'hDEAD_BEEF, 1'b0);
        tick(2'd1, 32'h12, 32'h55, 1'b0);
        tick(2'd0, 32'h10, 32'h0, 1'b0);
        chk("ram_byte", d_rd_data, 32'hDE55_BEEF);
        tick(2'd3, 32'h10, 32'h1234_5678, 1'b0);
        chk("raw_old", d_rd_data, 32'hDE55_BEEF);
        tick(2'd2, 32'h12, 32'hABCD, 1'b0);
        tick(2'd1, 32'h11, 32'h1FF, 1'b0);
        tick(2'd0, 32'h10, 32'h0, 1'b0);
        chk("ram_half", d_rd_data, 32'hABCD_FF78);
        tick(2'd0, 32'h1000, 32'h0, 1'b0);
        chk("unmap_rd", d_rd_data, 32'h0);
        tick(2'd3, A_TXS, 32'hFFFF_FFFF, 1'b0);
        chk("stat_empty", d_rd_data, 32'h2);
        tick(2'd0, A_TXD, 32'h0, 1'b0);
        chk("txd_rd", d_rd_data, 32'h0);
        chk("no_err", {31'b0, bus_err}, 32'h0);

        // cycle counter load, wrap and illegal size
        tick(2'd3, A_CYC, 32'hFFFF_FFFE, 1'b0);
        tick(2'd0, A_CYC, 32'h0, 1'b0);
        chk("cyc_ld", d_rd_data, 32'hFFFF_FFFE);
        tick(2'd0, A_CYC, 32'h0, 1'b0);
        chk("cyc_inc", d_rd_data, 32'hFFFF_FFFF);
        tick(2'd0, A_CYC, 32'h0, 1'b0);
        chk("cyc_wrap", d_rd_data, 32'h0);
        chk("cyc_err0", {31'b0, bus_err}, 32'h0);
        tick(2'd1, A_CYC, 32'h12, 1'b0);
        chk("cyc_byte_err", {31'b0, bus_err}, 32'h1);
        tick(2'd0, A_CYC, 32'h0, 1'b0);
        chk("cyc_noload", d_rd_data, 32'h2);

        // reset with FIFO data and a push in flight
        tick(2'd3, A_TXD, 32'h66, 1'b0);
        chk("push_valid", {31'b0, tx_valid}, 32'h1);
        chk("push_data", {24'b0, tx_data}, 32'h66);
        d_we = 2'd3;
        d_addr = A_TXD;
        d_wr_data = 32'h77;
        do_reset();
        tick(2'd0, A_TXS, 32'h0, 1'b0);
        chk("stat_after_rst", d_rd_data, 32'h2);

        // overflow with consumer stalled
        for (int i = 1; i <= 5; i++)
            tick(2'd3, A_TXD, 32'(i), 1'b0);
        tick(2'd0, A_TXS, 32'h0, 1'b0);
        chk("stat_full", d_rd_data, 32'h11);
        chk("ovf_err", {31'b0, bus_err}, 32'h1);
        chk("head", {24'b0, tx_data}, 32'h01);
        for (int i = 1; i <= 4; i++) begin
            pop_one(b);
            chk("drain", {24'b0, b}, 32'(i));
        end
        tick(2'd0, A_TXS, 32'h0, 1'b0);
        chk("stat_drained", d_rd_data, 32'h2);

        // push and pop together while full
        do_reset();
        for (int i = 0; i < 4; i++)
            tick(2'd3, A_TXD, 32'h11 + 32'(i), 1'b0);
        tick(2'd3, A_TXD, 32'hAA, 1'b1);
        chk("pp_err", {31'b0, bus_err}, 32'h0);
        tick(2'd0, A_TXS, 32'h0, 1'b0);
        chk("pp_stat", d_rd_data, 32'h11);
        for (int i = 0; i < 3; i++) begin
            pop_one(b);
            chk("pp_drain", {24'b0, b}, 32'h12 + 32'(i));
        end
        pop_one(b);
        chk("pp_last", {24'b0, b}, 32'hAA);
        chk("pp_err_end", {31'b0, bus_err}, 32'h0);

        // dropped writes and RAM persistence over reset
        do_reset();
        tick(2'd3, 32'h20, 32'hCAFE_F00D, 1'b0);
        tick(2'd3, 32'h4000_0000, 32'h1, 1'b0);
        chk("unmap_wr_err", {31'b0, bus_err}, 32'h1);
        do_reset();
        tick(2'd2, 32'h21, 32'h1234, 1'b0);
        chk("misal_err", {31'b0, bus_err}, 32'h1);
        tick(2'd3, 32'h22, 32'h5555_5555, 1'b0);
        tick(2'd0, 32'h20, 32'h0, 1'b0);
        chk("ram_kept", d_rd_data, 32'hCAFE_F00D);
        tick(2'd0, A_IDLE, 32'h0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
